// File: rtl/mini_cpu_pkg.sv
// mini_cpu_pkg: opcode map, FSM state encoding, flag bit positions and ALU
// operation selector shared by the core and its ALU.
package mini_cpu_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDI = 8'h01;
  localparam logic [7:0] OP_LD  = 8'h02;
  localparam logic [7:0] OP_ST  = 8'h03;
  localparam logic [7:0] OP_MOV = 8'h04;
  localparam logic [7:0] OP_MVA = 8'h05;
  localparam logic [7:0] OP_ADD = 8'h06;
  localparam logic [7:0] OP_SUB = 8'h07;
  localparam logic [7:0] OP_AND = 8'h08;
  localparam logic [7:0] OP_OR  = 8'h09;
  localparam logic [7:0] OP_XOR = 8'h0A;
  localparam logic [7:0] OP_JMP = 8'h0B;
  localparam logic [7:0] OP_JZ  = 8'h0C;
  localparam logic [7:0] OP_JN  = 8'h0D;
  localparam logic [7:0] OP_JC  = 8'h0E;
  localparam logic [7:0] OP_OUT = 8'h0F;
  localparam logic [7:0] OP_HLT = 8'hFF;

  // Bit positions inside the {Z,N,C,V} flags vector
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR
  } alu_op_e;

endpackage

// File: rtl/mini_cpu_alu.sv
// mini_cpu_alu: combinational accumulator ALU. Computes ACC op B and the
// resulting Z/N flags; C/V are only meaningful for ADD and SUB (C is the
// borrow for SUB).
module mini_cpu_alu
  import mini_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              v,
  output logic              z,
  output logic              n
);

  logic [DATA_W:0] wide;

  // Result and flag generation; extended-width add/sub exposes carry/borrow
  always_comb begin
    wide   = '0;
    result = b;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      ALU_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
        v      = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
        v      = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = b;
    endcase
    z = (result == '0);
    n = result[DATA_W-1];
  end

endmodule

// File: rtl/mini_cpu_core.sv
// mini_cpu_core: accumulator CPU with NUM_REGS general registers, a
// FETCH/EXEC/MEM/HALT state machine and a ready-handshaked data port.
// Optional feature macro MINI_CPU_SINGLE_STEP_EN adds step_mode/step inputs
// that hold the core in FETCH until a step pulse arrives.
// Addresses are taken from the low ADDR_W operand bits, so ADDR_W <= DATA_W.
module mini_cpu_core
  import mini_cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int OPC_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic [OPC_W+DATA_W-1:0] imem_data,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [ADDR_W-1:0]       dmem_addr,
  output logic [DATA_W-1:0]       dmem_wdata,
  input  logic [DATA_W-1:0]       dmem_rdata,
  input  logic                    dmem_ready,
  input  logic                    resume,
`ifdef MINI_CPU_SINGLE_STEP_EN
  input  logic                    step_mode,
  input  logic                    step,
`endif
  output logic                    halted,
  output logic                    illegal_op,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  output logic [3:0]              flags
);

  localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e                  state, next_state;
  logic [ADDR_W-1:0]       pc;
  logic [OPC_W+DATA_W-1:0] ir;
  logic [DATA_W-1:0]       acc;
  logic [DATA_W-1:0]       regs [NUM_REGS];

  logic [OPC_W-1:0]  opc;
  logic [DATA_W-1:0] operand;
  logic [RIDX_W-1:0] ridx;
  logic [DATA_W-1:0] reg_val;
  logic              mem_write;
  logic              fetch_go;

  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_v, alu_z, alu_n;

  logic wr_acc, upd_zn, upd_cv, wr_reg, jump, do_out, is_mem, is_halt, bad_op;

  assign opc       = ir[OPC_W+DATA_W-1:DATA_W];
  assign operand   = ir[DATA_W-1:0];
  assign ridx      = operand[RIDX_W-1:0];
  assign reg_val   = regs[ridx];
  assign mem_write = (opc == OPC_W'(OP_ST));

`ifdef MINI_CPU_SINGLE_STEP_EN
  assign fetch_go = !step_mode || step;
`else
  assign fetch_go = 1'b1;
`endif

  assign imem_addr  = pc;
  assign dmem_req   = (state == ST_MEM);
  assign dmem_we    = (state == ST_MEM) && mem_write;
  assign dmem_addr  = operand[ADDR_W-1:0];
  assign dmem_wdata = acc;
  assign halted     = (state == ST_HALT);

  mini_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (alu_op),
    .a      (acc),
    .b      (alu_b),
    .result (alu_res),
    .c      (alu_c),
    .v      (alu_v),
    .z      (alu_z),
    .n      (alu_n)
  );

  // Instruction decode into datapath enables for the EXEC cycle
  always_comb begin
    alu_op  = ALU_PASS;
    alu_b   = reg_val;
    wr_acc  = 1'b0;
    upd_zn  = 1'b0;
    upd_cv  = 1'b0;
    wr_reg  = 1'b0;
    jump    = 1'b0;
    do_out  = 1'b0;
    is_mem  = 1'b0;
    is_halt = 1'b0;
    bad_op  = 1'b0;
    case (opc)
      OPC_W'(OP_NOP): ;
      OPC_W'(OP_LDI): begin alu_b = operand; wr_acc = 1'b1; upd_zn = 1'b1; end
      OPC_W'(OP_LD),
      OPC_W'(OP_ST):  is_mem = 1'b1;
      OPC_W'(OP_MOV): wr_reg = 1'b1;
      OPC_W'(OP_MVA): begin wr_acc = 1'b1; upd_zn = 1'b1; end
      OPC_W'(OP_ADD): begin alu_op = ALU_ADD; wr_acc = 1'b1; upd_zn = 1'b1; upd_cv = 1'b1; end
      OPC_W'(OP_SUB): begin alu_op = ALU_SUB; wr_acc = 1'b1; upd_zn = 1'b1; upd_cv = 1'b1; end
      OPC_W'(OP_AND): begin alu_op = ALU_AND; wr_acc = 1'b1; upd_zn = 1'b1; end
      OPC_W'(OP_OR):  begin alu_op = ALU_OR;  wr_acc = 1'b1; upd_zn = 1'b1; end
      OPC_W'(OP_XOR): begin alu_op = ALU_XOR; wr_acc = 1'b1; upd_zn = 1'b1; end
      OPC_W'(OP_JMP): jump = 1'b1;
      OPC_W'(OP_JZ):  jump = flags[FLAG_Z];
      OPC_W'(OP_JN):  jump = flags[FLAG_N];
      OPC_W'(OP_JC):  jump = flags[FLAG_C];
      OPC_W'(OP_OUT): do_out = 1'b1;
      OPC_W'(OP_HLT): is_halt = 1'b1;
      default:        bad_op = 1'b1;
    endcase
  end

  // Next-state selection for the fetch/execute sequencer
  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH: if (fetch_go) next_state = ST_EXEC;
      ST_EXEC: begin
        if (is_mem)       next_state = ST_MEM;
        else if (is_halt) next_state = ST_HALT;
        else              next_state = ST_FETCH;
      end
      ST_MEM:  if (dmem_ready) next_state = ST_FETCH;
      ST_HALT: if (resume)     next_state = ST_FETCH;
      default: next_state = ST_FETCH;
    endcase
  end

  // State register; async reset forces FETCH so dmem_req drops immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_FETCH;
    else          state <= next_state;
  end

  // Architectural state: PC, IR, ACC, register file, flags and OUT port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= '0;
      ir         <= '0;
      acc        <= '0;
      flags      <= '0;
      illegal_op <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (fetch_go) begin
            ir <= imem_data;
            pc <= pc + ADDR_W'(1);
          end
        end
        ST_EXEC: begin
          if (wr_acc) acc <= alu_res;
          if (upd_zn) begin
            flags[FLAG_Z] <= alu_z;
            flags[FLAG_N] <= alu_n;
          end
          if (upd_cv) begin
            flags[FLAG_C] <= alu_c;
            flags[FLAG_V] <= alu_v;
          end
          if (wr_reg) regs[ridx] <= acc;
          if (jump) pc <= operand[ADDR_W-1:0];
          if (do_out) begin
            out_data  <= acc;
            out_valid <= 1'b1;
          end
          if (bad_op) illegal_op <= 1'b1;
        end
        ST_MEM: begin
          if (dmem_ready && !mem_write) begin
            acc           <= dmem_rdata;
            flags[FLAG_Z] <= (dmem_rdata == '0);
            flags[FLAG_N] <= dmem_rdata[DATA_W-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_cpu_core.sv
// tb_mini_cpu_core: self-checking bench for mini_cpu_core. Directed programs
// from the test plan plus randomly generated forward-only programs, all
// checked against an instruction-level reference model of the ISA.
module tb_mini_cpu_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic [7:0]  dmem_rdata;
  logic        dmem_ready;
  logic        resume;
  logic        halted;
  logic        illegal_op;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [3:0]  flags;

  logic [15:0] rom [256];
  logic [7:0]  ram [256];
  logic [7:0]  ram_init [256];

  int   checks = 0;
  int   errors = 0;
  int   wait_cnt;
  int   delay_fixed = 0;
  int   delay_rand = 0;
  bit   rand_delay = 1'b0;
  logic ready_noise = 1'b0;
  int   st_hold = 0;

  logic [11:0] out_q [$];
  logic [15:0] wr_q [$];
  logic [11:0] exp_out_q [$];
  logic [15:0] exp_wr_q [$];
  int          exp_pc;
  logic        exp_illegal;

  mini_cpu_core dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .resume     (resume),
`ifdef MINI_CPU_SINGLE_STEP_EN
    .step_mode  (1'b0),
    .step       (1'b0),
`endif
    .halted     (halted),
    .illegal_op (illegal_op),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .flags      (flags)
  );

  // Free-running 100 MHz core clock
  always #5 clk = ~clk;

  assign imem_data  = rom[imem_addr];
  assign dmem_rdata = ram[dmem_addr];
  // Ready only matters during a request; outside it we feed random noise
  // that the core has to ignore
  assign dmem_ready = dmem_req ? (wait_cnt >= (rand_delay ? delay_rand : delay_fixed)) : ready_noise;

  // Wait-state counter for the data RAM; also picks the next random latency
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 0;
    end else if (dmem_req && dmem_ready) begin
      wait_cnt   <= 0;
      delay_rand <= $urandom_range(0, 3);
    end else if (dmem_req) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // Data RAM: reloaded from the initial image while reset is held
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= ram_init[i];
    end else if (dmem_req && dmem_ready && dmem_we) begin
      ram[dmem_addr] <= dmem_wdata;
    end
  end

  // Random ready toggling between accesses
  always @(negedge clk) ready_noise <= 1'($urandom_range(0, 1));

  // Observation monitor: records OUT pulses, completed writes and how long
  // the test-plan store stays on the bus
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid) out_q.push_back({flags, out_data});
      if (dmem_req && dmem_ready && dmem_we) wr_q.push_back({dmem_addr, dmem_wdata});
      if (dmem_req && dmem_we && dmem_addr == 8'h10 && dmem_wdata == 8'h5A) st_hold <= st_hold + 1;
    end
  end

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] outAt(input int i);
    return (i < out_q.size()) ? 32'(out_q[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFF00;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pc"}, 32'(imem_addr), 0);
    checkOutput({tag, "_req"}, 32'(dmem_req), 0);
    checkOutput({tag, "_we"}, 32'(dmem_we), 0);
    checkOutput({tag, "_halted"}, 32'(halted), 0);
    checkOutput({tag, "_illegal"}, 32'(illegal_op), 0);
    checkOutput({tag, "_outdata"}, 32'(out_data), 0);
    checkOutput({tag, "_outvalid"}, 32'(out_valid), 0);
    checkOutput({tag, "_flags"}, 32'(flags), 0);
  endtask

  // Bounded wait for HALT; an expired budget shows up as a failed check
  task automatic runUntilHalt(input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("halt_reached", 32'(halted), 1);
  endtask

  task automatic applyStimulus(input int budget, output int cycles);
    resume  = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_q.delete();
    wr_q.delete();
    runUntilHalt(budget, cycles);
  endtask

  // ISA-level reference: runs the ROM program one instruction at a time
  // with integer arithmetic until the first HLT
  task automatic runModel();
    int         pc, acc, t, ri, b, steps;
    int         regs_m [8];
    logic [7:0] mem_m [256];
    logic [7:0] opc, opd;
    logic       z, n, c, v;
    bit         done;
    for (int i = 0; i < 256; i++) mem_m[i] = ram_init[i];
    for (int i = 0; i < 8; i++) regs_m[i] = 0;
    pc = 0; acc = 0; z = 0; n = 0; c = 0; v = 0;
    exp_illegal = 1'b0;
    done = 1'b0;
    steps = 0;
    exp_out_q.delete();
    exp_wr_q.delete();
    while (!done && steps < 1000) begin
      opc = rom[pc][15:8];
      opd = rom[pc][7:0];
      pc  = (pc + 1) % 256;
      steps++;
      ri = int'(opd) % 8;
      b  = regs_m[ri];
      case (opc)
        8'h00: ;
        8'h01: acc = int'(opd);
        8'h02: acc = int'(mem_m[opd]);
        8'h03: begin
          mem_m[opd] = 8'(acc);
          exp_wr_q.push_back({opd, 8'(acc)});
        end
        8'h04: regs_m[ri] = acc;
        8'h05: acc = b;
        8'h06: begin
          t   = sx(acc) + sx(b);
          v   = (t > 127) || (t < -128);
          c   = (acc + b) > 255;
          acc = (acc + b) % 256;
        end
        8'h07: begin
          t   = sx(acc) - sx(b);
          v   = (t > 127) || (t < -128);
          c   = acc < b;
          acc = (acc - b + 256) % 256;
        end
        8'h08: acc = acc & b;
        8'h09: acc = acc | b;
        8'h0A: acc = acc ^ b;
        8'h0B: pc = int'(opd);
        8'h0C: if (z) pc = int'(opd);
        8'h0D: if (n) pc = int'(opd);
        8'h0E: if (c) pc = int'(opd);
        8'h0F: exp_out_q.push_back({z, n, c, v, 8'(acc)});
        8'hFF: done = 1'b1;
        default: exp_illegal = 1'b1;
      endcase
      if (opc inside {8'h01, 8'h02, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A}) begin
        z = (acc == 0);
        n = (acc >= 128);
      end
    end
    exp_pc = pc;
  endtask

  task automatic compareRun(input string tag);
    int nmin;
    runModel();
    checkOutput({tag, "_pc"}, 32'(imem_addr), 32'(exp_pc));
    checkOutput({tag, "_illegal"}, 32'(illegal_op), 32'(exp_illegal));
    checkOutput({tag, "_nout"}, out_q.size(), exp_out_q.size());
    nmin = (out_q.size() < exp_out_q.size()) ? out_q.size() : exp_out_q.size();
    for (int i = 0; i < nmin; i++)
      checkOutput($sformatf("%s_out%0d", tag, i), 32'(out_q[i]), 32'(exp_out_q[i]));
    checkOutput({tag, "_nwr"}, wr_q.size(), exp_wr_q.size());
    nmin = (wr_q.size() < exp_wr_q.size()) ? wr_q.size() : exp_wr_q.size();
    for (int i = 0; i < nmin; i++)
      checkOutput($sformatf("%s_wr%0d", tag, i), 32'(wr_q[i]), 32'(exp_wr_q[i]));
  endtask

  // Random forward-only program: jumps always target a later address so
  // every program reaches the HLT at address 40
  task automatic genProgram();
    int         k;
    logic [7:0] opc, opd;
    clearRom();
    for (int a = 0; a < 40; a++) begin
      k   = $urandom_range(0, 15);
      opd = 8'($urandom_range(0, 255));
      case (k)
        0:  opc = 8'h01;
        1:  begin opc = 8'h02; opd = opd & 8'h1F; end
        2:  begin opc = 8'h03; opd = opd & 8'h1F; end
        3:  opc = 8'h04;
        4:  opc = 8'h05;
        5, 15: opc = 8'h06;
        6:  opc = 8'h07;
        7:  opc = 8'h08;
        8:  opc = 8'h09;
        9:  opc = 8'h0A;
        10: begin
          opc = 8'($urandom_range(11, 14));
          opd = 8'(a + 1 + int'($urandom_range(0, 39 - a)));
        end
        11, 12: opc = 8'h0F;
        13: opc = 8'($urandom_range(16, 254));
        default: opc = 8'h00;
      endcase
      rom[a] = {opc, opd};
    end
  endtask

  // Main sequence: reset, test-plan programs, then random programs
  initial begin
    int cyc;
    int st0;
    resume = 1'b0;
    for (int i = 0; i < 256; i++) ram_init[i] = 8'($urandom_range(0, 255));
    clearRom();

    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;
    checkResetState("rst");

    // 5 + 3 = 8 through R1, then OUT and HLT
    clearRom();
    rom[0] = 16'h0105; rom[1] = 16'h0401; rom[2] = 16'h0103;
    rom[3] = 16'h0601; rom[4] = 16'h0F00; rom[5] = 16'hFF00;
    applyStimulus(200, cyc);
    checkOutput("t1_cycles", cyc, 12);
    checkOutput("t1_out", outAt(0), 32'h008);
    compareRun("t1");

    // Signed overflow on ADD, then SUB with overflow and no borrow
    clearRom();
    rom[0] = 16'h017F; rom[1] = 16'h0402; rom[2] = 16'h0101; rom[3] = 16'h0602;
    rom[4] = 16'h0F00; rom[5] = 16'h0702; rom[6] = 16'h0F00; rom[7] = 16'hFF00;
    applyStimulus(200, cyc);
    checkOutput("t2_cycles", cyc, 16);
    checkOutput("t2_add", outAt(0), 32'h580);
    checkOutput("t2_sub", outAt(1), 32'h101);
    compareRun("t2");

    // Store with three wait states, then load it back
    delay_fixed = 3;
    clearRom();
    rom[0] = 16'h015A; rom[1] = 16'h0310; rom[2] = 16'h0100;
    rom[3] = 16'h0210; rom[4] = 16'h0F00; rom[5] = 16'hFF00;
    st0 = st_hold;
    applyStimulus(200, cyc);
    checkOutput("t3_cycles", cyc, 20);
    checkOutput("t3_hold", st_hold - st0, 4);
    checkOutput("t3_nwr", wr_q.size(), 1);
    checkOutput("t3_ram", 32'(ram[8'h10]), 32'h5A);
    checkOutput("t3_ld", outAt(0), 32'h05A);
    compareRun("t3");
    delay_fixed = 0;

    // JZ taken/not taken, JMP to 0xFF and PC wrap back to 0
    clearRom();
    rom[0]    = 16'h0500; rom[1]    = 16'h0C10; rom[2]    = 16'h0F00; rom[3] = 16'hFF00;
    rom[8'h10] = 16'h0101; rom[8'h11] = 16'h0400; rom[8'h12] = 16'h0C30;
    rom[8'h13] = 16'h0F00; rom[8'h14] = 16'h0BFF; rom[8'hFF] = 16'h0000;
    applyStimulus(200, cyc);
    checkOutput("t4_cycles", cyc, 24);
    checkOutput("t4_nout", out_q.size(), 2);
    checkOutput("t4_pc", 32'(imem_addr), 4);
    compareRun("t4");

    // Undefined opcode is a NOP that sets a sticky illegal_op
    clearRom();
    rom[0] = 16'h0133; rom[1] = 16'h4200; rom[2] = 16'h0F00;
    rom[3] = 16'h0100; rom[4] = 16'h0F00; rom[5] = 16'hFF00;
    applyStimulus(200, cyc);
    checkOutput("t5_acc", outAt(0), 32'h033);
    checkOutput("t5_zero", outAt(1), 32'h800);
    checkOutput("t5_illegal", 32'(illegal_op), 1);
    compareRun("t5");

    // Reset asserted while a load is waiting on the bus
    delay_fixed = 10;
    clearRom();
    rom[0] = 16'h0180; rom[1] = 16'h0F00; rom[2] = 16'h4200;
    rom[3] = 16'h0220; rom[4] = 16'hFF00;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    checkOutput("mid_req", 32'(dmem_req), 1);
    checkOutput("mid_illegal", 32'(illegal_op), 1);
    checkOutput("mid_flags", 32'(flags), 32'h4);
    reset_n = 1'b0;
    #1;
    checkResetState("midmem");
    delay_fixed = 0;

    // HLT, wait five cycles, resume and continue after the HLT
    clearRom();
    rom[0] = 16'h0111; rom[1] = 16'hFF00; rom[2] = 16'h0F00; rom[3] = 16'hFF00;
    applyStimulus(200, cyc);
    checkOutput("t6_cycles", cyc, 4);
    checkOutput("t6_pc", 32'(imem_addr), 2);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t6_sticky", 32'(halted), 1);
    resume = 1'b1;
    @(posedge clk);
    #1;
    resume = 1'b0;
    checkOutput("t6_resumed", 32'(halted), 0);
    runUntilHalt(200, cyc);
    checkOutput("t6_out", outAt(0), 32'h011);
    checkOutput("t6_pc2", 32'(imem_addr), 4);

    // Random programs with random wait states
    rand_delay = 1'b1;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 256; i++) ram_init[i] = 8'($urandom_range(0, 255));
      genProgram();
      applyStimulus(2000, cyc);
      compareRun($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
